l2_request_arbiter: RTL and testbench
=====================================

# l2_request_arbiter

Shares the single L2 memory port between the four L1 requesters: data cache, data MMU, instruction cache and instruction MMU. The arbiter grants one request at a time in round-robin order and forwards it to L2 with its requester ID and burst size. For writes, it holds the grant while it streams the burst's data beats. Read-return beats are registered and steered back to the issuing requester by ID. The block sits between the L1 units and the L2/bus interface.

## Interface
- NUM_REQ, 4: number of requesters; index equals `l1_connection_id`.
- ADDR_W, 32: address width.
- DATA_W, 32: data beat width.
- clk  in  1  core clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending per requester.
- req_ready  out  NUM_REQ  request accepted; one-hot or zero.
- req_addr  in  NUM_REQ×ADDR_W  byte address, word aligned.
- req_rnw  in  NUM_REQ  1 = read, 0 = write.
- req_size  in  NUM_REQ×3  burst length, encoded as `l2_burst_size_t`.
- wr_data  in  NUM_REQ×DATA_W  write beat.
- wr_valid  in  NUM_REQ  write beat available.
- wr_ready  out  NUM_REQ  write beat consumed.
- l2_req_valid / l2_req_ready  out / in  1  L2 request handshake.
- l2_addr  out  ADDR_W;  l2_rnw  out  1;  l2_size  out  3;  l2_id  out  2.
- l2_wr_data  out  DATA_W;  l2_wr_valid  out  1;  l2_wr_ready  in  1.
- l2_rd_data  in  DATA_W;  l2_rd_valid  in  1;  l2_rd_id  in  2.
- rd_data  out  DATA_W  registered read beat, broadcast to all requesters.
- rd_valid  out  NUM_REQ  one-hot, indicates the beat belongs to that requester.

## Operation
- FSM states:
  - IDLE: selects a winner among `req_valid`.
  - ISSUE: drives the winner on the L2 request outputs.
  - WDATA: streams write beats.
- IDLE → ISSUE whenever any `req_valid` is high.
- Winner selection:
  - The search starts at `rr_ptr` and proceeds upward, wrapping modulo NUM_REQ.
  - The winner index and its address, rnw and size are latched into registers.
- In ISSUE, `l2_req_valid`=1 and all L2 request fields come from the latched registers.
- On `l2_req_ready`:
  - `req_ready[winner]` pulses for that same cycle.
  - `rr_ptr` is set to winner+1 (mod NUM_REQ).
  - Read: next state is IDLE.
  - Write: the beat counter loads with the beat count, and next state is WDATA.
- Beat count decode: SIZE_1→1, SIZE_4→4, SIZE_8→8, SIZE_16→16, SIZE_32→32, SIZE_64→64. Codes 6 and 7 decode to 1.
- Counter width is 7 bits.
- WDATA:
  - `l2_wr_data` = `wr_data[winner]`.
  - `l2_wr_valid` = `wr_valid[winner]`.
  - `wr_ready[winner]` = `l2_wr_ready`.
  - Each beat where valid and ready are both high decrements the counter.
  - The final beat (counter==1) returns the FSM to IDLE.
- Read return is independent of the FSM:
  - Each cycle, `rd_data` <= `l2_rd_data`.
  - `rd_valid` <= `l2_rd_valid` ? onehot(`l2_rd_id`) : 0.
  - Reads may therefore return while another request is being issued or written.
- A requester must hold `req_valid` and its fields stable until `req_ready`. The arbiter does not re-sample `req_*` after latching.
- If the winner deasserts `req_valid` before `req_ready`, that is a protocol violation. The request is still issued; a bench assertion flags it.
- Reset (asynchronous, any state):
  - FSM → IDLE, `rr_ptr`=0, counter=0.
  - All outputs 0: `req_ready`, `wr_ready`, `l2_req_valid`, `l2_wr_valid`, `rd_valid`, `rd_data`, and the latched `l2_addr`/`l2_rnw`/`l2_size`/`l2_id`.
  - An in-flight burst is abandoned; L2 is reset alongside.

## Timing
- Request latency, from `req_valid` rising with no contention: IDLE samples at edge 0; `l2_req_valid` is high from cycle 1.
- With `l2_req_ready` held at 1, `req_ready` pulses in cycle 1. Minimum occupancy is therefore 2 cycles per read.
- A write takes 2 + beats cycles minimum, with no bubble between ISSUE and the first beat.
- After IDLE is re-entered, a new grant takes 1 cycle. A back-to-back read stream yields one L2 request every 2 cycles.
- Read return latency is exactly 1 cycle from `l2_rd_valid` to `rd_valid`.
- Simultaneous requests from all four requesters after reset are granted in order 0,1,2,3.
- A requester that holds `req_valid` continuously waits at most NUM_REQ−1 other grants.

## Structure
- Shared config package holds:
  - `l1_connection_id` and `l2_burst_size_t`.
  - New `arb_state_t` enum {IDLE, ISSUE, WDATA}.
  - New function `burst_beats(l2_burst_size_t)` returning the 7-bit beat count.
- One sub-module, `rr_priority_select`: combinational round-robin picker taking NUM_REQ request bits and a pointer, returning a one-hot grant and a valid flag. The FSM, counter and return path stay in the top level.

## Test plan
- Reset mid-WDATA, with counter=5 and `rst_n` low for 1 cycle → all outputs 0 and FSM IDLE. The next request from requester 3 issues with `l2_id`=3.
- All four requesters issue reads of size SIZE_1 at addresses 0x20000000+0x10·i, with `l2_req_ready`=1 → `l2_id` sequence 0,1,2,3, one request every 2 cycles, each `req_ready` a single-cycle pulse.
- Requester 0 (dcache) writes SIZE_4 with data 0xA0..0xA3, `l2_wr_ready` toggling 1,0,1,0 → exactly 4 beats reach L2 in order, then IDLE. Requester 2's concurrent request waits until the burst completes.
- `l2_req_ready` held low for 10 cycles with a request pending → `l2_req_valid` and all L2 fields stay stable and `req_ready` stays 0; on ready, a single accept occurs.
- `l2_rd_valid` with `l2_rd_id`=2 and data 0xDEADBEEF arrives during an issue from requester 1 → next cycle `rd_valid`=0100 and `rd_data`=0xDEADBEEF; the issue is unaffected.
- Requester 1 holds `req_valid` continuously while requesters 0, 2 and 3 keep re-requesting → requester 1 is granted within 3 grants every round.

Source files
------------

// File: rtl/l2_request_arbiter_pkg.sv
// l2_request_arbiter_pkg: L1 requester IDs, L2 burst encodings and arbiter state shared by the L2 request arbiter.
package l2_request_arbiter_pkg;
    typedef enum logic [1:0] {L1_DCACHE, L1_DMMU, L1_ICACHE, L1_IMMU} l1_connection_id;
    typedef enum logic [2:0] {SIZE_1, SIZE_4, SIZE_8, SIZE_16, SIZE_32, SIZE_64} l2_burst_size_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WDATA} arb_state_t;
    localparam int ID_W = $bits(l1_connection_id);
    localparam int BEAT_W = 7;
    function automatic logic [BEAT_W-1:0] burst_beats(input l2_burst_size_t size);
        case (size)
            SIZE_4:  return 7'd4;
            SIZE_8:  return 7'd8;
            SIZE_16: return 7'd16;
            SIZE_32: return 7'd32;
            SIZE_64: return 7'd64;
            default: return 7'd1;
        endcase
    endfunction
endpackage

// File: rtl/l2_request_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker; the first request at or above ptr (wrapping) wins.
module rr_priority_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);
    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) grant = N'(1) << ((int'(ptr) + i) % N);
    end
    assign valid = |req;
endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin sharing of the single L2 request port among the L1 requesters,
// with write-burst streaming and ID-steered registered read return.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]              req_rnw,
    input  logic [NUM_REQ-1:0][2:0]         req_size,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  wr_data,
    input  logic [NUM_REQ-1:0]              wr_valid,
    output logic [NUM_REQ-1:0]              wr_ready,
    output logic                            l2_req_valid,
    input  logic                            l2_req_ready,
    output logic [ADDR_W-1:0]               l2_addr,
    output logic                            l2_rnw,
    output logic [2:0]                      l2_size,
    output logic [ID_W-1:0]                 l2_id,
    output logic [DATA_W-1:0]               l2_wr_data,
    output logic                            l2_wr_valid,
    input  logic                            l2_wr_ready,
    input  logic [DATA_W-1:0]               l2_rd_data,
    input  logic                            l2_rd_valid,
    input  logic [ID_W-1:0]                 l2_rd_id,
    output logic [DATA_W-1:0]               rd_data,
    output logic [NUM_REQ-1:0]              rd_valid
);
    arb_state_t state, state_next;
    logic [NUM_REQ-1:0] grant;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx, win_q, rr_ptr;
    logic [ADDR_W-1:0]  addr_q;
    logic               rnw_q;
    logic [2:0]         size_q;
    logic [BEAT_W-1:0]  beats;
    logic               beat_fire;

    rr_priority_select #(.N(NUM_REQ)) u_sel (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (sel_valid)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) sel_idx = ID_W'(i);
    end

    assign beat_fire = state == WDATA && wr_valid[win_q] && l2_wr_ready;

    always_comb begin
        state_next   = state;
        req_ready    = '0;
        wr_ready     = '0;
        l2_req_valid = state == ISSUE;
        l2_wr_valid  = state == WDATA && wr_valid[win_q];
        l2_wr_data   = state == WDATA ? wr_data[win_q] : '0;
        case (state)
            IDLE:  if (sel_valid) state_next = ISSUE;
            ISSUE: if (l2_req_ready) begin
                req_ready[win_q] = 1'b1;
                state_next       = rnw_q ? IDLE : WDATA;
            end
            WDATA: begin
                wr_ready[win_q] = l2_wr_ready;
                if (beat_fire && beats == 7'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once at selection; the requester is not re-sampled afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beats    <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            size_q   <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            state    <= state_next;
            rd_data  <= l2_rd_data;
            rd_valid <= l2_rd_valid ? NUM_REQ'(1) << l2_rd_id : '0;
            if (state == IDLE && sel_valid) begin
                win_q  <= sel_idx;
                addr_q <= req_addr[sel_idx];
                rnw_q  <= req_rnw[sel_idx];
                size_q <= req_size[sel_idx];
            end
            if (state == ISSUE && l2_req_ready) begin
                rr_ptr <= win_q == ID_W'(NUM_REQ - 1) ? '0 : win_q + 1'b1;
                if (!rnw_q) beats <= burst_beats(l2_burst_size_t'(size_q));
            end
            if (beat_fire) beats <= beats - 1'b1;
        end
    end

    assign l2_addr = addr_q;
    assign l2_rnw  = rnw_q;
    assign l2_size = size_q;
    assign l2_id   = win_q;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter: randomized requesters and L2 against a transaction-level arbitration model.
module tb_l2_request_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          req_valid, req_ready, req_rnw, wr_valid, wr_ready, rd_valid;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][2:0]     req_size;
    logic [N-1:0][DW-1:0]  wr_data;
    logic                  l2_req_valid, l2_req_ready, l2_rnw, l2_wr_valid, l2_wr_ready, l2_rd_valid;
    logic [AW-1:0]         l2_addr;
    logic [2:0]            l2_size;
    logic [1:0]            l2_id, l2_rd_id;
    logic [DW-1:0]         l2_wr_data, l2_rd_data, rd_data;

    l2_request_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rnw(req_rnw),
        .req_size(req_size), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_addr(l2_addr),
        .l2_rnw(l2_rnw), .l2_size(l2_size), .l2_id(l2_id),
        .l2_wr_data(l2_wr_data), .l2_wr_valid(l2_wr_valid), .l2_wr_ready(l2_wr_ready),
        .l2_rd_data(l2_rd_data), .l2_rd_valid(l2_rd_valid), .l2_rd_id(l2_rd_id),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    // The winner must keep requesting until it is accepted.
    assert property (@(posedge clk) disable iff (!rst_n) l2_req_valid |-> req_valid[l2_id])
        else $error("protocol violation: winner %0d dropped req_valid before req_ready", l2_id);

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        return a ^ (32'(b) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    int beats_tbl[8] = '{1, 4, 8, 16, 32, 64, 1, 1};

    // model: who owns the port, which transaction, how far the burst has gone
    int          m_phase = 0;
    int          m_ptr = 0, m_win = 0, m_left = 0, m_sent = 0;
    logic [31:0] m_addr;
    logic        m_rnw;
    logic [2:0]  m_size;
    logic [N-1:0] m_rdv = '0;
    logic [31:0] m_rdd = '0;

    logic [31:0] d_addr[N];
    int          d_left[N], d_b[N], waitc[N];
    logic [N-1:0] acc_req = '0, acc_wr = '0;
    bit          did_rst = 0, force3 = 0;

    task automatic check_all_zero(input string tag);
        chk({tag, ".req_ready"}, req_ready, 0);
        chk({tag, ".wr_ready"}, wr_ready, 0);
        chk({tag, ".l2_req_valid"}, l2_req_valid, 0);
        chk({tag, ".l2_wr_valid"}, l2_wr_valid, 0);
        chk({tag, ".rd_valid"}, rd_valid, 0);
        chk({tag, ".rd_data"}, rd_data, 0);
        chk({tag, ".l2_addr"}, l2_addr, 0);
        chk({tag, ".l2_rnw"}, l2_rnw, 0);
        chk({tag, ".l2_size"}, l2_size, 0);
        chk({tag, ".l2_id"}, l2_id, 0);
    endtask

    task automatic clear_stimulus();
        req_valid = '0; req_rnw = '0; req_addr = '0; req_size = '0;
        wr_valid = '0; wr_data = '0;
        l2_req_ready = 0; l2_wr_ready = 0; l2_rd_valid = 0; l2_rd_id = 0; l2_rd_data = 0;
        for (int i = 0; i < N; i++) begin
            d_left[i] = 0; d_b[i] = 0; d_addr[i] = 0; waitc[i] = 0;
        end
        acc_req = '0; acc_wr = '0;
    endtask

    initial begin
        logic         e_l2v, e_wv, found;
        logic [N-1:0] e_rr, e_wr;
        clear_stimulus();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!did_rst && cyc > 1500 && m_phase == 2 && (m_left == 5 || cyc > 3000)) begin
                did_rst = 1;
                rst_n = 1'b0;
                clear_stimulus();
                #1;
                check_all_zero("midburst_reset");
                m_phase = 0; m_ptr = 0; m_rdv = '0; m_rdd = '0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                force3 = 1;
            end
            l2_req_ready = cyc < 12 ? 1'b1 : (cyc >= 300 && cyc < 310) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
            l2_wr_ready = 1'($urandom_range(0, 1));
            l2_rd_valid = 1'($urandom_range(0, 1));
            l2_rd_id = 2'($urandom_range(0, 3));
            l2_rd_data = $urandom;
            for (int i = 0; i < N; i++) begin
                if (acc_req[i]) begin
                    req_valid[i] = 1'b0;
                    if (!req_rnw[i]) begin
                        d_left[i] = beats_tbl[req_size[i]];
                        d_b[i] = 0;
                        d_addr[i] = req_addr[i];
                    end
                end
                if (acc_wr[i]) begin
                    d_b[i]++;
                    d_left[i]--;
                end
                if (cyc == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i] = 32'h2000_0000 + 32'h10 * i;
                    req_rnw[i] = 1'b1;
                    req_size[i] = 3'd0;
                end else if (!req_valid[i] && cyc >= 12 && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i] = $urandom & 32'hFFFF_FFFC;
                    req_rnw[i] = 1'($urandom_range(0, 1));
                    req_size[i] = 3'($urandom_range(0, 7));
                end
                wr_valid[i] = d_left[i] > 0 && $urandom_range(0, 3) != 0;
                wr_data[i] = d_left[i] > 0 ? beat_data(d_addr[i], d_b[i]) : $urandom;
            end
            if (force3) begin
                force3 = 0;
                req_valid = 4'b1000;
                req_addr[3] = 32'h3000_0040;
                req_rnw[3] = 1'b1;
                req_size[3] = 3'd0;
            end
            #1;
            e_l2v = m_phase == 1;
            e_rr = (m_phase == 1 && l2_req_ready) ? 4'(1 << m_win) : 4'd0;
            e_wv = m_phase == 2 && wr_valid[m_win];
            e_wr = (m_phase == 2 && l2_wr_ready) ? 4'(1 << m_win) : 4'd0;
            chk("l2_req_valid", l2_req_valid, e_l2v);
            if (e_l2v) begin
                chk("l2_id", l2_id, m_win);
                chk("l2_addr", l2_addr, m_addr);
                chk("l2_rnw", l2_rnw, m_rnw);
                chk("l2_size", l2_size, m_size);
            end
            chk("req_ready", req_ready, e_rr);
            chk("wr_ready", wr_ready, e_wr);
            chk("l2_wr_valid", l2_wr_valid, e_wv);
            if (e_wv) chk("l2_wr_data", l2_wr_data, beat_data(m_addr, m_sent));
            chk("rd_valid", rd_valid, m_rdv);
            chk("rd_data", rd_data, m_rdd);
            acc_req = req_ready;
            acc_wr = wr_ready & wr_valid;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    chk("fair_wait_le3", waitc[i] <= 3, 1);
                    waitc[i] = 0;
                end else if (req_valid[i] && req_ready != 0) begin
                    waitc[i]++;
                end
            end
            m_rdv = l2_rd_valid ? 4'(1 << l2_rd_id) : 4'd0;
            m_rdd = l2_rd_data;
            if (m_phase == 0) begin
                if (req_valid != 0) begin
                    found = 0;
                    for (int k = 0; k < N; k++)
                        if (!found && req_valid[(m_ptr + k) % N]) begin
                            found = 1;
                            m_win = (m_ptr + k) % N;
                        end
                    m_addr = req_addr[m_win];
                    m_rnw = req_rnw[m_win];
                    m_size = req_size[m_win];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (l2_req_ready) begin
                    m_ptr = (m_win + 1) % N;
                    if (m_rnw) m_phase = 0;
                    else begin
                        m_phase = 2;
                        m_left = beats_tbl[m_size];
                        m_sent = 0;
                    end
                end
            end else if (wr_valid[m_win] && l2_wr_ready) begin
                m_sent++;
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
            @(posedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
